kbd_io_bridge: RTL and testbench

Memory-mapped keyboard ring-buffer writer: the device-side master of the shared data-memory I/O port (B port). It accepts decoded key bytes from the PS/2 front end and appends them to a ring buffer in data memory. It maintains the head index there and reads the tail index the CPU program advances. The CPU program consumes the buffer with ordinary loads and stores on the A port.

---
 rtl/kbd_io_pkg.sv | 10 +
 rtl/kbd_io_bridge.sv | 99 +++++++++
 tb/tb_kbd_io_bridge.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_io_pkg.sv
// kbd_io_pkg: shared types and layout constants for the keyboard ring-buffer bridge
package kbd_io_pkg;
   typedef enum logic [2:0] {
      INIT_HEAD, INIT_TAIL, IDLE, RD_TAIL, WAIT_RD, CHECK, WR_DATA, WR_HEAD
   } state_t;
   localparam int HEAD_OFS = 0;
   localparam int TAIL_OFS = 1;
   localparam int DATA_OFS = 2;
   localparam int DROP_W   = 8;
endpackage

// File: rtl/kbd_io_bridge.sv
// kbd_io_bridge: appends PS/2 key bytes to a ring buffer in data memory via the B port
module kbd_io_bridge
   import kbd_io_pkg::*;
#(
   parameter logic [31:0] BASE_WORD = 32'h0000_0400,
   parameter int          DEPTH     = 16,
   parameter int          RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              kbd_valid,
   input  logic [7:0]        kbd_data,
   output logic              kbd_ready,
   output logic              io_req,
   input  logic              io_gnt,
   output logic [31:0]       io_addr,
   output logic              io_wren,
   output logic [31:0]       io_wdata,
   input  logic [31:0]       io_rdata,
   output logic [DROP_W-1:0] drop_cnt
);
   localparam int HW = $clog2(DEPTH);
   localparam int CW = RD_LAT > 2 ? $clog2(RD_LAT) : 1;
   state_t state, state_nxt;
   logic [HW-1:0] head, head_inc, tail;
   logic [7:0] key;
   logic [CW-1:0] wcnt;
   logic [DROP_W-1:0] drops;
   logic full, unused_rdata;
   assign head_inc = head + 1'b1;
   assign tail = io_rdata[HW-1:0];
   assign full = head_inc == tail;
   assign unused_rdata = ^io_rdata[31:HW];
   assign drop_cnt = drops;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= INIT_HEAD;
         head  <= '0;
         key   <= '0;
         wcnt  <= '0;
         drops <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= (state == WAIT_RD) ? wcnt + 1'b1 : '0;
         if (state == IDLE && kbd_valid) key <= kbd_data;
         if (state == WR_HEAD && io_gnt) head <= head_inc;
         if (state == CHECK && full && drops != '1) drops <= drops + 1'b1;
      end
   end
   always_comb begin
      state_nxt = state;
      kbd_ready = 1'b0;
      io_req    = 1'b0;
      io_wren   = 1'b0;
      io_addr   = '0;
      io_wdata  = '0;
      unique case (state)
         INIT_HEAD: begin
            {io_req, io_wren} = 2'b11;
            io_addr = BASE_WORD + 32'(HEAD_OFS);
            state_nxt = io_gnt ? INIT_TAIL : state;
         end
         INIT_TAIL: begin
            {io_req, io_wren} = 2'b11;
            io_addr = BASE_WORD + 32'(TAIL_OFS);
            state_nxt = io_gnt ? IDLE : state;
         end
         IDLE: begin
            kbd_ready = 1'b1;
            state_nxt = kbd_valid ? RD_TAIL : state;
         end
         RD_TAIL: begin
            io_req  = 1'b1;
            io_addr = BASE_WORD + 32'(TAIL_OFS);
            state_nxt = !io_gnt ? state : (RD_LAT == 1) ? CHECK : WAIT_RD;
         end
         WAIT_RD: state_nxt = (wcnt == CW'(RD_LAT - 2)) ? CHECK : state;
         CHECK:   state_nxt = full ? IDLE : WR_DATA;
         WR_DATA: begin
            {io_req, io_wren} = 2'b11;
            io_addr  = BASE_WORD + 32'(DATA_OFS) + 32'(head);
            io_wdata = {24'h0, key};
            state_nxt = io_gnt ? WR_HEAD : state;
         end
         WR_HEAD: begin
            {io_req, io_wren} = 2'b11;
            io_addr  = BASE_WORD + 32'(HEAD_OFS);
            io_wdata = 32'(head_inc);
            state_nxt = io_gnt ? IDLE : state;
         end
      endcase
      // while held in reset the port stays quiet even though state already reads INIT
      if (!rst) begin
         {kbd_ready, io_req, io_wren} = 3'b000;
         io_addr  = '0;
         io_wdata = '0;
      end
   end
endmodule

// File: tb/tb_kbd_io_bridge.sv
// tb_kbd_io_bridge: drives RD_LAT=1 and RD_LAT=3 bridges against a behavioural memory
// and a ring-buffer reference model.
module tb_kbd_io_bridge;
   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam int DEPTH = 16;
   localparam int NW = DEPTH + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2], kbd_valid [2], kbd_ready [2];
   logic        io_req [2], io_gnt [2], io_wren [2];
   logic [7:0]  kbd_data [2], drop_cnt [2];
   logic [31:0] io_addr [2], io_wdata [2], io_rdata [2];

   logic [31:0] mem [2][NW];
   logic [31:0] rp [2][3];
   logic [31:0] rv;
   logic        acc [2], acc_wr [2], pend [2], cpu_we [2];
   int          acc_off [2], cpu_off [2];
   logic [31:0] acc_wd [2], cpu_wd [2];
   logic [65:0] prev [2];
   bit          rnd;
   int          checks, errors;
   int          hd [2], drops [2];
   logic [7:0]  ent [2][DEPTH];
   bit          known [2][DEPTH];

   kbd_io_bridge #(.BASE_WORD(BASE), .DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst[0]), .kbd_valid(kbd_valid[0]), .kbd_data(kbd_data[0]),
      .kbd_ready(kbd_ready[0]), .io_req(io_req[0]), .io_gnt(io_gnt[0]), .io_addr(io_addr[0]),
      .io_wren(io_wren[0]), .io_wdata(io_wdata[0]), .io_rdata(io_rdata[0]), .drop_cnt(drop_cnt[0]));

   kbd_io_bridge #(.BASE_WORD(BASE), .DEPTH(DEPTH), .RD_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst[1]), .kbd_valid(kbd_valid[1]), .kbd_data(kbd_data[1]),
      .kbd_ready(kbd_ready[1]), .io_req(io_req[1]), .io_gnt(io_gnt[1]), .io_addr(io_addr[1]),
      .io_wren(io_wren[1]), .io_wdata(io_wdata[1]), .io_rdata(io_rdata[1]), .drop_cnt(drop_cnt[1]));

   assign io_rdata[0] = rp[0][0];
   assign io_rdata[1] = rp[1][2];

   task automatic chk(string tag, logic [71:0] obs, logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Port snapshot half a cycle before each edge; also checks request hold and wren gating.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst[d] && pend[d])
            chk($sformatf("hold_%0d", d), 72'({io_req[d], io_wren[d], io_addr[d], io_wdata[d]}), 72'(prev[d]));
         if (!io_req[d]) chk($sformatf("wren_idle_%0d", d), 72'(io_wren[d]), 72'(0));
         acc_off[d] = int'(io_addr[d] - BASE);
         acc[d]     = rst[d] && io_req[d] && io_gnt[d] && acc_off[d] >= 0 && acc_off[d] < NW;
         acc_wr[d]  = io_wren[d];
         acc_wd[d]  = io_wdata[d];
         pend[d]    = rst[d] && io_req[d] && !io_gnt[d];
         prev[d]    = {io_req[d], io_wren[d], io_addr[d], io_wdata[d]};
      end
   end

   // Synchronous memory; read data appears RD_LAT cycles after the granted read, noise otherwise.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         rv = $urandom;
         if (cpu_we[d]) mem[d][cpu_off[d]] = cpu_wd[d];
         if (acc[d] && acc_wr[d]) mem[d][acc_off[d]] = acc_wd[d];
         if (acc[d] && !acc_wr[d]) rv = mem[d][acc_off[d]];
         rp[d][0] <= rv;
         rp[d][1] <= rp[d][0];
         rp[d][2] <= rp[d][1];
      end
   end

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) io_gnt[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(int d, int off, logic [31:0] v);
      cpu_off[d] = off;
      cpu_wd[d]  = v;
      cpu_we[d]  = 1'b1;
      step();
      cpu_we[d]  = 1'b0;
   endtask

   task automatic wait_ready(int d);
      int k = 0;
      while (!kbd_ready[d] && k < 300) begin
         step();
         k++;
      end
      chk("ready_timeout", 72'(kbd_ready[d]), 72'(1));
   endtask

   task automatic rst_seq(int d, bit tchk);
      rst[d] = 1'b0;
      step();
      step();
      chk("rst_ctl", 72'({kbd_ready[d], io_req[d], io_wren[d], drop_cnt[d]}), 72'(0));
      chk("rst_bus", 72'({io_addr[d], io_wdata[d]}), 72'(0));
      rst[d]   = 1'b1;
      hd[d]    = 0;
      drops[d] = 0;
      if (tchk) begin
         #1;
         chk("init_head", 72'({io_req[d], io_wren[d], io_addr[d], io_wdata[d]}), 72'({2'b11, BASE, 32'h0}));
         step();
         chk("init_tail", 72'({kbd_ready[d], io_req[d], io_wren[d], io_addr[d], io_wdata[d]}),
             72'({3'b011, BASE + 32'd1, 32'h0}));
         step();
         chk("ready_after_init", 72'(kbd_ready[d]), 72'(1));
      end else wait_ready(d);
      chk("mem_head0", 72'(mem[d][0]), 72'(0));
      chk("mem_tail0", 72'(mem[d][1]), 72'(0));
   endtask

   task automatic send(int d, logic [7:0] b, bit tchk);
      int  n, tail, lat;
      bit  full;
      lat = (d == 0) ? 1 : 3;
      wait_ready(d);
      tail = int'(mem[d][1] & 32'(DEPTH - 1));
      full = ((hd[d] + 1) % DEPTH) == tail;
      kbd_valid[d] = 1'b1;
      kbd_data[d]  = b;
      step();
      kbd_valid[d] = 1'b0;
      n = 1;
      while (!kbd_ready[d] && n < 300) begin
         step();
         n++;
      end
      if (tchk) chk("spacing", 72'(n), 72'(full ? lat + 2 : lat + 4));
      if (full) drops[d] = (drops[d] < 255) ? drops[d] + 1 : 255;
      else begin
         ent[d][hd[d]]   = b;
         known[d][hd[d]] = 1'b1;
         hd[d] = (hd[d] + 1) % DEPTH;
      end
      chk("head", 72'(mem[d][0]), 72'(hd[d]));
      chk("drop_cnt", 72'(drop_cnt[d]), 72'(drops[d]));
   endtask

   task automatic check_entries(int d);
      for (int i = 0; i < DEPTH; i++)
         if (known[d][i]) chk($sformatf("entry%0d", i), 72'(mem[d][2+i]), 72'({24'h0, ent[d][i]}));
   endtask

   initial begin
      logic [7:0]  b;
      logic [31:0] r;
      int          k;
      rnd = 1'b0;
      checks = 0;
      errors = 0;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0;
         kbd_valid[d] = 1'b0;
         kbd_data[d] = 8'h0;
         cpu_we[d] = 1'b0;
         cpu_off[d] = 0;
         cpu_wd[d] = 32'h0;
         hd[d] = 0;
         drops[d] = 0;
         for (int i = 0; i < DEPTH; i++) known[d][i] = 1'b0;
      end
      step();
      step();
      for (int d = 0; d < 2; d++) begin
         // fill to DEPTH-1, drop on full, then wrap after the consumer advances
         rst_seq(d, 1'b1);
         send(d, 8'h1C, 1'b1);
         send(d, 8'h32, 1'b1);
         send(d, 8'h21, 1'b1);
         for (int i = 0; i < 12; i++) send(d, 8'($urandom), 1'b1);
         send(d, 8'($urandom), 1'b1);
         chk("full_drop", 72'(drop_cnt[d]), 72'(1));
         chk("full_head", 72'(mem[d][0]), 72'(15));
         cpu_wr(d, 1, 32'd4);
         b = 8'($urandom);
         send(d, b, 1'b1);
         chk("wrap_entry15", 72'(mem[d][17]), 72'({24'h0, b}));
         chk("wrap_head", 72'(mem[d][0]), 72'(0));
         check_entries(d);
         // reset while the head write is on the bus
         wait_ready(d);
         b = 8'($urandom);
         kbd_valid[d] = 1'b1;
         kbd_data[d]  = b;
         step();
         kbd_valid[d] = 1'b0;
         k = 0;
         while (!(io_req[d] && io_wren[d] && io_addr[d] == BASE) && k < 50) begin
            step();
            k++;
         end
         chk("wr_head_seen", 72'({io_req[d], io_wren[d], io_addr[d]}), 72'({2'b11, BASE}));
         ent[d][hd[d]]   = b;
         known[d][hd[d]] = 1'b1;
         rst[d] = 1'b0;
         step();
         chk("no_head_update", 72'(mem[d][0]), 72'(hd[d]));
         chk("drop_cleared", 72'(drop_cnt[d]), 72'(0));
         rst_seq(d, 1'b1);
         // random grants and random consumer positions
         rnd = 1'b1;
         for (int i = 0; i < 48; i++) begin
            if (i % 8 == 0) begin
               r = $urandom;
               cpu_wr(d, 1, (r & ~32'hF) | 32'($urandom_range(0, DEPTH - 1)));
            end
            send(d, 8'($urandom), 1'b0);
         end
         rnd = 1'b0;
         check_entries(d);
         // saturation: buffer held full for 300 bytes
         rst_seq(d, 1'b1);
         cpu_wr(d, 1, 32'd1);
         for (int i = 0; i < 300; i++) send(d, 8'($urandom), 1'b1);
         chk("drop_sat", 72'(drop_cnt[d]), 72'(255));
         chk("sat_head", 72'(mem[d][0]), 72'(0));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
